imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 125 ++++++++++++
 tb/tb_imem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Two-requester round-robin arbiter in front of a combinational
//               instruction ROM, with range checking and per-requester flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
   parameter int N   = 32,
   parameter int INS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_0,
   input  logic         req_1,
   input  logic [N-1:0] addr_0,
   input  logic [N-1:0] addr_1,
   input  logic         flush_0,
   input  logic         flush_1,
   output logic         gnt_0,
   output logic         gnt_1,
   output logic         rvalid_0,
   output logic         rvalid_1,
   output logic [N-1:0] rdata_0,
   output logic [N-1:0] rdata_1,
   output logic         rerr_0,
   output logic         rerr_1,
   output logic [N-1:0] mem_pc,
   input  logic [N-1:0] mem_instruction
);

   localparam logic [1:0]   c_idle   = 2'd0;
   localparam logic [1:0]   c_access = 2'd1;
   localparam logic [1:0]   c_resp   = 2'd2;
   localparam logic [N-1:0] c_ins    = N'(INS);

   logic [1:0]   r_state;
   logic         r_owner;
   logic         r_ptr;
   logic [N-1:0] r_addr;
   logic [N-1:0] r_rdata_0;
   logic [N-1:0] r_rdata_1;
   logic         r_rerr_0;
   logic         r_rerr_1;

   logic         w_idle;
   logic         w_access;
   logic         w_resp;
   logic         w_gnt_0;
   logic         w_gnt_1;
   logic         w_in_range;
   logic         w_flush_own;
   logic [N-1:0] w_capture;

   assign w_idle   = (r_state == c_idle);
   assign w_access = (r_state == c_access);
   assign w_resp   = (r_state == c_resp);

   // Grants are gated by rst_n so they read 0 while reset is held.
   assign w_gnt_0 = rst_n & w_idle & req_0 & (~req_1 | ~r_ptr);
   assign w_gnt_1 = rst_n & w_idle & req_1 & (~req_0 |  r_ptr);

   assign w_in_range  = (r_addr < c_ins);
   assign w_flush_own = r_owner ? flush_1 : flush_0;
   assign w_capture   = w_in_range ? mem_instruction : '0;

   assign gnt_0    = w_gnt_0;
   assign gnt_1    = w_gnt_1;
   assign mem_pc   = (w_access && w_in_range) ? r_addr : '0;
   assign rvalid_0 = w_resp & ~r_owner & ~w_flush_own;
   assign rvalid_1 = w_resp &  r_owner & ~w_flush_own;
   assign rdata_0  = r_rdata_0;
   assign rdata_1  = r_rdata_1;
   assign rerr_0   = r_rerr_0;
   assign rerr_1   = r_rerr_1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
         r_owner <= 1'b0;
         r_ptr   <= 1'b0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_gnt_0 || w_gnt_1) begin
                  r_owner <= w_gnt_1;
                  r_addr  <= w_gnt_1 ? addr_1 : addr_0;
                  r_ptr   <= ~w_gnt_1;
                  r_state <= c_access;
               end
            end
            c_access: begin
               // An owner flush cancels the fetch before the response phase.
               r_state <= w_flush_own ? c_idle : c_resp;
            end
            c_resp: begin
               r_state <= c_idle;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata_0 <= '0;
         r_rdata_1 <= '0;
         r_rerr_0  <= 1'b0;
         r_rerr_1  <= 1'b0;
      end else if (w_access && !w_flush_own) begin
         if (r_owner) begin
            r_rdata_1 <= w_capture;
            r_rerr_1  <= ~w_in_range;
         end else begin
            r_rdata_0 <= w_capture;
            r_rerr_0  <= ~w_in_range;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level reference model of imem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

   localparam int N   = 32;
   localparam int INS = 10;
   localparam int AW  = $clog2(INS);

   logic         clk;
   logic         rst_n;
   logic         req_0, req_1, flush_0, flush_1;
   logic [N-1:0] addr_0, addr_1;
   logic         gnt_0, gnt_1, rvalid_0, rvalid_1, rerr_0, rerr_1;
   logic [N-1:0] rdata_0, rdata_1, mem_pc, mem_instruction;

   logic [N-1:0] rom [INS];
   int checks = 0;
   int errors = 0;

   imem_arbiter #(.N(N), .INS(INS)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_0           (req_0),
      .req_1           (req_1),
      .addr_0          (addr_0),
      .addr_1          (addr_1),
      .flush_0         (flush_0),
      .flush_1         (flush_1),
      .gnt_0           (gnt_0),
      .gnt_1           (gnt_1),
      .rvalid_0        (rvalid_0),
      .rvalid_1        (rvalid_1),
      .rdata_0         (rdata_0),
      .rdata_1         (rdata_1),
      .rerr_0          (rerr_0),
      .rerr_1          (rerr_1),
      .mem_pc          (mem_pc),
      .mem_instruction (mem_instruction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Out-of-range ROM reads return a marker the DUT must never capture.
   assign mem_instruction = (mem_pc < INS) ? rom[mem_pc[AW-1:0]] : 32'hBAD0_BAD0;

   task automatic drive_idle();
      req_0 = 1'b0; req_1 = 1'b0; flush_0 = 1'b0; flush_1 = 1'b0;
      addr_0 = '0;  addr_1 = '0;
   endtask

   task automatic reset_dut();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [N-1:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       return N'($urandom_range(0, INS - 1));
      else if (r < 9)  return N'($urandom_range(INS, INS + 3));
      else             return N'($urandom);
   endfunction

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0; req_0 = 1'b1; addr_0 = 3;
      #1;
      checks++;
      if ({gnt_0, gnt_1, rvalid_0, rvalid_1, rerr_0, rerr_1} !== 6'b0) begin
         errors++; $display("FAIL reset_flags got=%b exp=000000", {gnt_0, gnt_1, rvalid_0, rvalid_1, rerr_0, rerr_1});
      end
      checks++;
      if (mem_pc !== '0 || rdata_0 !== '0 || rdata_1 !== '0) begin
         errors++; $display("FAIL reset_data got pc=%h rd0=%h rd1=%h exp=0", mem_pc, rdata_0, rdata_1);
      end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (gnt_0 !== 1'b1) begin errors++; $display("FAIL reset_first_gnt got=%b exp=1", gnt_0); end
      @(negedge clk); #1;
      checks++;
      if (mem_pc !== 32'd3) begin errors++; $display("FAIL reset_access_pc got=%h exp=3", mem_pc); end
      rst_n = 1'b0; req_0 = 1'b1; req_1 = 1'b1; #1;
      checks++;
      if ({gnt_0, gnt_1, rvalid_0, rvalid_1} !== 4'b0 || mem_pc !== '0) begin
         errors++; $display("FAIL reset_mid_access got=%b pc=%h exp=0000 pc=0", {gnt_0, gnt_1, rvalid_0, rvalid_1}, mem_pc);
      end
      @(negedge clk); @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0 || rvalid_0 !== 1'b0) begin
         errors++; $display("FAIL reset_release_rr got g0=%b g1=%b rv0=%b exp g0=1 g1=0 rv0=0", gnt_0, gnt_1, rvalid_0);
      end
      @(negedge clk); req_0 = 1'b0; req_1 = 1'b0; #1;
      checks++;
      if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL reset_no_stale_rvalid got=%b exp=0", rvalid_0); end
      @(negedge clk); #1;
      checks++;
      if (rvalid_0 !== 1'b1 || rdata_0 !== rom[3]) begin
         errors++; $display("FAIL reset_refetch got rv0=%b rd0=%h exp rv0=1 rd0=%h", rvalid_0, rdata_0, rom[3]);
      end
   endtask

   task automatic test_single_fetch();
      @(negedge clk); req_0 = 1'b1; addr_0 = 3; #1;
      checks++;
      if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL single_gnt got g0=%b g1=%b exp 1 0", gnt_0, gnt_1); end
      @(negedge clk); req_0 = 1'b0; #1;
      checks++;
      if (mem_pc !== 32'd3 || gnt_0 !== 1'b0 || rvalid_0 !== 1'b0) begin
         errors++; $display("FAIL single_access got pc=%h g0=%b rv0=%b exp pc=3 g0=0 rv0=0", mem_pc, gnt_0, rvalid_0);
      end
      @(negedge clk); #1;
      checks++;
      if (rvalid_0 !== 1'b1 || rdata_0 !== 32'h00A00093 || rerr_0 !== 1'b0 || rvalid_1 !== 1'b0 || mem_pc !== '0) begin
         errors++; $display("FAIL single_resp got rv0=%b rd0=%h er0=%b rv1=%b pc=%h exp 1 00a00093 0 0 0", rvalid_0, rdata_0, rerr_0, rvalid_1, mem_pc);
      end
      @(negedge clk); #1;
      checks++;
      if (rvalid_0 !== 1'b0 || rdata_0 !== 32'h00A00093) begin
         errors++; $display("FAIL single_hold got rv0=%b rd0=%h exp 0 00a00093", rvalid_0, rdata_0);
      end
   endtask

   task automatic test_contention();
      bit            own;
      logic [N-1:0]  exp_pc;
      reset_dut();
      req_0 = 1'b1; addr_0 = 1; req_1 = 1'b1; addr_1 = 2;
      for (int c = 0; c < 12; c++) begin
         #1;
         own    = ((c / 3) % 2) == 1;
         exp_pc = (c % 3 == 1) ? (own ? 32'd2 : 32'd1) : 32'd0;
         checks++;
         if (gnt_0 !== (c % 3 == 0 && !own) || gnt_1 !== (c % 3 == 0 && own)) begin
            errors++; $display("FAIL contention_gnt c=%0d got g0=%b g1=%b", c, gnt_0, gnt_1);
         end
         checks++;
         if (rvalid_0 !== (c % 3 == 2 && !own) || rvalid_1 !== (c % 3 == 2 && own) || mem_pc !== exp_pc) begin
            errors++; $display("FAIL contention_resp c=%0d got rv0=%b rv1=%b pc=%h exp pc=%h", c, rvalid_0, rvalid_1, mem_pc, exp_pc);
         end
         if (c % 3 == 2) begin
            checks++;
            if ((!own && rdata_0 !== rom[1]) || (own && rdata_1 !== rom[2])) begin
               errors++; $display("FAIL contention_data c=%0d got rd0=%h rd1=%h exp %h/%h", c, rdata_0, rdata_1, rom[1], rom[2]);
            end
         end
         @(negedge clk);
      end
      req_0 = 1'b0; req_1 = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [N-1:0] tbl [4];
      logic [N-1:0] a;
      bit           ok;
      tbl[0] = 32'd10; tbl[1] = 32'd9; tbl[2] = 32'hFFFF_FFFF; tbl[3] = 32'h8000_0003;
      for (int i = 0; i < 4; i++) begin
         a  = tbl[i];
         ok = (a < INS);
         @(negedge clk); req_1 = 1'b1; addr_1 = a; #1;
         checks++;
         if (gnt_1 !== 1'b1) begin errors++; $display("FAIL range_gnt a=%h got=%b exp=1", a, gnt_1); end
         @(negedge clk); req_1 = 1'b0; #1;
         checks++;
         if (mem_pc !== (ok ? a : 32'd0)) begin errors++; $display("FAIL range_pc a=%h got=%h exp=%h", a, mem_pc, ok ? a : 32'd0); end
         @(negedge clk); #1;
         checks++;
         if (rvalid_1 !== 1'b1 || rdata_1 !== (ok ? rom[a[AW-1:0]] : 32'd0) || rerr_1 !== !ok) begin
            errors++; $display("FAIL range_resp a=%h got rv1=%b rd1=%h er1=%b exp er1=%b", a, rvalid_1, rdata_1, rerr_1, !ok);
         end
      end
   endtask

   task automatic test_flush();
      @(negedge clk); req_1 = 1'b1; addr_1 = 5; #1;
      checks++;
      if (gnt_1 !== 1'b1) begin errors++; $display("FAIL flush_gnt1 got=%b exp=1", gnt_1); end
      @(negedge clk); req_1 = 1'b0; flush_1 = 1'b1; req_0 = 1'b1; addr_0 = 4; #1;
      checks++;
      if (mem_pc !== 32'd5 || gnt_0 !== 1'b0) begin errors++; $display("FAIL flush_access got pc=%h g0=%b exp 5 0", mem_pc, gnt_0); end
      @(negedge clk); flush_1 = 1'b0; #1;
      checks++;
      if (rvalid_1 !== 1'b0 || gnt_0 !== 1'b1) begin errors++; $display("FAIL flush_cancel got rv1=%b g0=%b exp 0 1", rvalid_1, gnt_0); end
      checks++;
      if (rdata_1 !== 32'd0 || rerr_1 !== 1'b1) begin errors++; $display("FAIL flush_hold1 got rd1=%h er1=%b exp 0 1", rdata_1, rerr_1); end
      @(negedge clk); req_0 = 1'b0; #1;
      checks++;
      if (mem_pc !== 32'd4) begin errors++; $display("FAIL flush_next_pc got=%h exp=4", mem_pc); end
      @(negedge clk); #1;
      checks++;
      if (rvalid_0 !== 1'b1 || rdata_0 !== rom[4]) begin errors++; $display("FAIL flush_next_resp got rv0=%b rd0=%h exp 1 %h", rvalid_0, rdata_0, rom[4]); end
      // Owner flush during the response cycle must hide rvalid.
      @(negedge clk); req_0 = 1'b1; addr_0 = 6;
      @(negedge clk); req_0 = 1'b0;
      @(negedge clk); flush_0 = 1'b1; #1;
      checks++;
      if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL flush_resp got rv0=%b exp=0", rvalid_0); end
      @(negedge clk); flush_0 = 1'b0;
   endtask

   task automatic test_nonowner_flush();
      @(negedge clk); req_1 = 1'b1; addr_1 = 7; #1;
      checks++;
      if (gnt_1 !== 1'b1) begin errors++; $display("FAIL nonown_gnt got=%b exp=1", gnt_1); end
      @(negedge clk); req_1 = 1'b0; flush_0 = 1'b1; #1;
      checks++;
      if (mem_pc !== 32'd7) begin errors++; $display("FAIL nonown_pc got=%h exp=7", mem_pc); end
      @(negedge clk); #1;
      checks++;
      if (rvalid_1 !== 1'b1 || rdata_1 !== rom[7] || rerr_1 !== 1'b0 || rvalid_0 !== 1'b0) begin
         errors++; $display("FAIL nonown_resp got rv1=%b rd1=%h er1=%b rv0=%b exp 1 %h 0 0", rvalid_1, rdata_1, rerr_1, rvalid_0, rom[7]);
      end
      flush_0 = 1'b0;
   endtask

   task automatic test_random();
      int           g, ph, winner;
      bit           killed, g_owner, prefer, drop0, drop1, active, fl_own;
      logic [N-1:0] g_addr, e_pc;
      logic [N-1:0] exp_rd [2];
      bit           exp_er [2];
      reset_dut();
      g = -10; killed = 1'b0; g_owner = 1'b0; prefer = 1'b0; g_addr = '0;
      drop0 = 1'b0; drop1 = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (drop0) begin req_0 = 1'b0; drop0 = 1'b0; end
         if (drop1) begin req_1 = 1'b0; drop1 = 1'b0; end
         if (!req_0 && $urandom_range(0, 99) < 45) begin req_0 = 1'b1; addr_0 = pick_addr(); end
         if (!req_1 && $urandom_range(0, 99) < 45) begin req_1 = 1'b1; addr_1 = pick_addr(); end
         flush_0 = ($urandom_range(0, 99) < 12);
         flush_1 = ($urandom_range(0, 99) < 12);
         #1;
         // A fetch occupies the two cycles after its grant unless cancelled.
         ph     = cyc - g;
         active = (ph >= 1) && (ph <= 2) && !killed;
         fl_own = g_owner ? flush_1 : flush_0;
         winner = -1;
         if (!active) begin
            if (req_0 && req_1) winner = prefer ? 1 : 0;
            else if (req_0)     winner = 0;
            else if (req_1)     winner = 1;
         end
         e_pc = (active && ph == 1 && g_addr < INS) ? g_addr : '0;
         checks++;
         if (gnt_0 !== (winner == 0) || gnt_1 !== (winner == 1)) begin
            errors++; $display("FAIL rnd_gnt cyc=%0d got g0=%b g1=%b exp winner=%0d", cyc, gnt_0, gnt_1, winner);
         end
         checks++;
         if (mem_pc !== e_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, mem_pc, e_pc); end
         checks++;
         if (rvalid_0 !== (active && ph == 2 && !fl_own && !g_owner) || rvalid_1 !== (active && ph == 2 && !fl_own && g_owner)) begin
            errors++; $display("FAIL rnd_rvalid cyc=%0d got rv0=%b rv1=%b", cyc, rvalid_0, rvalid_1);
         end
         checks++;
         if (rdata_0 !== exp_rd[0] || rdata_1 !== exp_rd[1] || rerr_0 !== exp_er[0] || rerr_1 !== exp_er[1]) begin
            errors++; $display("FAIL rnd_data cyc=%0d got %h/%b %h/%b exp %h/%b %h/%b", cyc, rdata_0, rerr_0, rdata_1, rerr_1, exp_rd[0], exp_er[0], exp_rd[1], exp_er[1]);
         end
         if (active && fl_own) begin
            killed = 1'b1;
         end else if (active && ph == 1) begin
            exp_rd[g_owner] = (g_addr < INS) ? rom[g_addr[AW-1:0]] : '0;
            exp_er[g_owner] = !(g_addr < INS);
         end
         if (winner >= 0) begin
            g       = cyc;
            g_owner = winner[0];
            g_addr  = winner[0] ? addr_1 : addr_0;
            killed  = 1'b0;
            prefer  = !winner[0];
            if (winner[0]) drop1 = 1'b1; else drop0 = 1'b1;
         end
         @(negedge clk);
      end
      drive_idle();
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();
      for (int i = 0; i < INS; i++) rom[i] = $urandom;
      rom[3] = 32'h00A00093;
      test_reset();
      test_single_fetch();
      test_contention();
      test_out_of_range();
      test_flush();
      test_nonowner_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
